// File: rtl/reg_handshake_tx_pkg.sv
// Shared definitions for the toggle-handshake register transmitter:
// FSM encoding and the width helper for the acknowledge wait counter.
package reg_handshake_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((32'sd1 <<< w) < value) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_handshake_tx_bit_sync.sv
// Two-flop single-bit synchronizer for a level crossing into the clk domain.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    // Two-stage capture of the asynchronous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reg_handshake_tx.sv
// Source side of a req/ack toggle handshake: holds one word on data_o per
// transfer, coalesces writes made while busy (last write wins).
module reg_handshake_tx
    import reg_handshake_tx_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             wr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             req_o,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o
);

    localparam int            CW      = clog2_min1(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic          TO_EN   = (TIMEOUT != 0) ? 1'b1 : 1'b0;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] shadow_q;
    logic             req_q;
    logic             pending_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             hit_d;
    logic             ack_s;
    logic             ack_det_s;

    bit_sync u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ack_i),
        .q_o (ack_s)
    );

    // The far side has caught up once its echoed level matches ours.
    assign ack_det_s = (ack_s == req_q);

    // Saturating wait counter and the edge at which it first hits the limit.
    always_comb begin
        cnt_d = cnt_q;
        hit_d = 1'b0;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
            hit_d = TO_EN && (cnt_d == CNT_MAX);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Transfer FSM with shadow/pending coalescing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            shadow_q  <= '0;
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_i) begin
                        data_q  <= data_i;
                        req_q   <= ~req_q;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (ack_det_s) begin
                        done_q <= 1'b1;
                        // A write in the ack cycle is newer than the shadow.
                        if (wr_i) begin
                            data_q    <= data_i;
                            req_q     <= ~req_q;
                            pending_q <= 1'b0;
                            cnt_q     <= '0;
                        end else if (pending_q) begin
                            data_q    <= shadow_q;
                            req_q     <= ~req_q;
                            pending_q <= 1'b0;
                            cnt_q     <= '0;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (hit_d) begin
                            timeout_q <= 1'b1;
                        end
                        if (wr_i) begin
                            shadow_q  <= data_i;
                            pending_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o    = data_q;
    assign req_o     = req_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_reg_handshake_tx.sv
// Self-checking bench for reg_handshake_tx: directed scenarios plus a
// randomized far side checked against a last-write-wins reference model.
`timescale 1ns/1ps
module tb_reg_handshake_tx;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic             clk     = 1'b0;
    logic             far_clk = 1'b0;
    logic             rst     = 1'b1;
    logic             wr_i    = 1'b0;
    logic [WIDTH-1:0] data_i  = '0;
    logic             man_ack = 1'b0;
    logic             far_en  = 1'b0;
    logic             far_ack = 1'b0;
    logic             ack_i;
    logic [WIDTH-1:0] data_o;
    logic             req_o;
    logic             busy_o;
    logic             done_o;
    logic             timeout_o;

    int               total = 0;
    int               bad   = 0;
    int               far_cnt = 0;
    realtime          far_half = 7.0;
    logic [WIDTH-1:0] rx_q[$];
    logic [WIDTH-1:0] exp_q[$];

    assign ack_i = far_en ? far_ack : man_ack;

    reg_handshake_tx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .wr_i      (wr_i),
        .data_o    (data_o),
        .req_o     (req_o),
        .ack_i     (ack_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;
    always #(far_half) far_clk = ~far_clk;

    // Far side: after a random latency, capture data_o and echo req as ack.
    always @(posedge far_clk) begin
        if (!far_en) begin
            far_ack <= 1'b0;
            far_cnt <= 0;
        end else if (req_o != far_ack) begin
            if (far_cnt == 0) begin
                far_cnt <= int'($urandom_range(50, 1));
            end else if (far_cnt == 1) begin
                rx_q.push_back(data_o);
                far_ack <= req_o;
                far_cnt <= 0;
            end else begin
                far_cnt <= far_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; wr_i = 1'b0; man_ack = 1'b0; far_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_i = 1'b1; data_i = 32'hFFFF_FFFF; man_ack = 1'b0;
        tick();
        tick();
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
        total++; if ({req_o, busy_o, done_o, timeout_o} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {req_o, busy_o, done_o, timeout_o}); end
        wr_i = 1'b0; rst = 1'b0;
        tick();
        total++; if ({req_o, busy_o} !== 2'b00) begin bad++; $display("FAIL reset_idle: got %b want 00", {req_o, busy_o}); end
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] got;
        apply_reset();
        wr_i = 1'b1; data_i = 32'hDEAD_BEEF;
        tick();
        wr_i = 1'b0; data_i = 32'h0;
        total++; if (data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", data_o); end
        total++; if ({req_o, busy_o, done_o} !== 3'b110) begin bad++; $display("FAIL single_req: got %b want 110", {req_o, busy_o, done_o}); end
        repeat (5) tick();
        got = data_o;
        man_ack = 1'b1;
        tick();
        tick();
        total++; if ({done_o, busy_o} !== 2'b01) begin bad++; $display("FAIL single_early_done: got %b want 01", {done_o, busy_o}); end
        tick();
        total++; if ({done_o, busy_o} !== 2'b10) begin bad++; $display("FAIL single_done: got %b want 10", {done_o, busy_o}); end
        tick();
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL single_pulse: got %b want 0", done_o); end
        total++; if (got !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rx: got %h want deadbeef", got); end
    endtask

    task automatic test_coalesce();
        logic [WIDTH-1:0] first;
        logic [WIDTH-1:0] second;
        int               extra;
        apply_reset();
        wr_i = 1'b1; data_i = 32'h1; tick();
        data_i = 32'h2; tick();
        data_i = 32'h3; tick();
        wr_i = 1'b0;
        first = data_o;
        total++; if (first !== 32'h1) begin bad++; $display("FAIL coal_first: got %h want 1", first); end
        man_ack = 1'b1;
        repeat (3) tick();
        total++; if ({done_o, busy_o, req_o} !== 3'b110) begin bad++; $display("FAIL coal_done1: got %b want 110", {done_o, busy_o, req_o}); end
        second = data_o;
        total++; if (second !== 32'h3) begin bad++; $display("FAIL coal_second: got %h want 3", second); end
        man_ack = 1'b0;
        repeat (3) tick();
        total++; if ({done_o, busy_o} !== 2'b10) begin bad++; $display("FAIL coal_done2: got %b want 10", {done_o, busy_o}); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_o === 1'b1 || req_o !== 1'b0) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL coal_extra: got %0d want 0", extra); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        wr_i = 1'b1; data_i = 32'h11; tick();
        wr_i = 1'b0;
        man_ack = 1'b1;
        tick();
        tick();
        wr_i = 1'b1; data_i = 32'hA5;
        tick();
        wr_i = 1'b0;
        total++; if ({done_o, busy_o, req_o} !== 3'b110) begin bad++; $display("FAIL simul_done: got %b want 110", {done_o, busy_o, req_o}); end
        total++; if (data_o !== 32'hA5) begin bad++; $display("FAIL simul_data: got %h want a5", data_o); end
        man_ack = 1'b0;
        repeat (3) tick();
        total++; if ({done_o, busy_o} !== 2'b10) begin bad++; $display("FAIL simul_done2: got %b want 10", {done_o, busy_o}); end
        repeat (5) tick();
        total++; if ({req_o, busy_o} !== 2'b00) begin bad++; $display("FAIL simul_single: got %b want 00", {req_o, busy_o}); end
    endtask

    task automatic test_timeout();
        int early;
        apply_reset();
        wr_i = 1'b1; data_i = 32'h5A; tick();
        wr_i = 1'b0;
        early = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            if (timeout_o !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL timeout_early: got %0d want 0", early); end
        tick();
        total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_rise: got %b want 1", timeout_o); end
        man_ack = 1'b1;
        repeat (3) tick();
        total++; if ({done_o, busy_o, timeout_o} !== 3'b101) begin bad++; $display("FAIL timeout_late_ack: got %b want 101", {done_o, busy_o, timeout_o}); end
        tick();
        total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", timeout_o); end
    endtask

    task automatic test_reset_mid();
        int stray;
        apply_reset();
        wr_i = 1'b1; data_i = 32'h1; tick();
        data_i = 32'h2; tick();
        wr_i = 1'b0;
        rst = 1'b1; man_ack = 1'b0;
        tick();
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL rstmid_data: got %h want 0", data_o); end
        total++; if ({req_o, busy_o, done_o, timeout_o} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags: got %b want 0000", {req_o, busy_o, done_o, timeout_o}); end
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done_o !== 1'b0 || busy_o !== 1'b0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rstmid_stray: got %0d want 0", stray); end
        wr_i = 1'b1; data_i = 32'h77; tick();
        wr_i = 1'b0;
        total++; if ({req_o, busy_o, data_o} !== {2'b11, 32'h77}) begin bad++; $display("FAIL rstmid_next: got %b %h want 11 77", {req_o, busy_o}, data_o); end
    endtask

    task automatic test_random();
        logic             m_busy;
        logic             m_pend;
        logic             m_req;
        logic [WIDTH-1:0] m_shadow;
        logic [WIDTH-1:0] m_cur;
        logic             wr_now;
        logic [WIDTH-1:0] d_now;
        logic [WIDTH-1:0] prev_data;
        logic             prev_req;
        logic             prev_busy;
        int               sent;
        int               gap;
        int               cyc;
        int               errs;
        apply_reset();
        rx_q.delete();
        exp_q.delete();
        far_en = 1'b1;
        m_busy = 1'b0; m_pend = 1'b0; m_req = 1'b0; m_shadow = '0; m_cur = '0;
        d_now = '0; sent = 0; gap = 0; cyc = 0; errs = 0;
        prev_data = data_o; prev_req = req_o; prev_busy = busy_o;
        while ((sent < 1000 || m_busy) && cyc < 60000) begin
            wr_now = 1'b0;
            if (sent < 1000) begin
                if (gap == 0) begin
                    if (sent % 100 == 0) far_half = 1.5 + real'($urandom_range(135, 0)) / 10.0;
                    wr_now = 1'b1;
                    d_now  = $urandom;
                    gap    = int'($urandom_range(40, 0));
                    sent++;
                end else begin
                    gap--;
                end
            end
            wr_i = wr_now; data_i = d_now;
            tick();
            if (!m_busy) begin
                if (wr_now) begin
                    m_cur = d_now; m_req = ~m_req; m_busy = 1'b1; exp_q.push_back(d_now);
                end
            end else if (done_o === 1'b1) begin
                if (wr_now) begin
                    m_cur = d_now; m_req = ~m_req; m_pend = 1'b0; exp_q.push_back(d_now);
                end else if (m_pend) begin
                    m_cur = m_shadow; m_req = ~m_req; m_pend = 1'b0; exp_q.push_back(m_shadow);
                end else begin
                    m_busy = 1'b0;
                end
            end else if (wr_now) begin
                m_shadow = d_now; m_pend = 1'b1;
            end
            total++;
            if (data_o !== m_cur || req_o !== m_req || busy_o !== m_busy) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_state: got %h %b %b want %h %b %b", data_o, req_o, busy_o, m_cur, m_req, m_busy);
            end
            if (prev_busy === 1'b1 && data_o !== prev_data && req_o === prev_req) begin
                bad++; errs++; total++;
                if (errs < 10) $display("FAIL rand_stable: got %h want %h", data_o, prev_data);
            end
            prev_data = data_o; prev_req = req_o; prev_busy = busy_o;
            cyc++;
        end
        wr_i = 1'b0;
        total++; if (cyc >= 60000) begin bad++; $display("FAIL rand_budget: got %0d cycles want < 60000", cyc); end
        total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        errs = 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rand_seq: got %0d differing words want 0", errs); end
        far_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_coalesce();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
        test_random();
        apply_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
